risc_v_cpu: RTL and testbench



---
 rtl/risc_v_cpu_if.sv | 21 ++
 rtl/risc_v_cpu.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_risc_v_cpu.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/risc_v_cpu_if.sv
// Data-memory bus between the RV32I core and its word-wide data RAM.
// Byte enables select lanes on writes; reads are combinational.
interface risc_v_cpu_if #(
  parameter int AW = 8
);
  logic [AW-1:0] idx;
  logic [31:0]   wdata;
  logic [3:0]    be;
  logic          we;
  logic [31:0]   rdata;

  modport master (
    output idx, wdata, be, we,
    input  rdata
  );

  modport slave (
    input  idx, wdata, be, we,
    output rdata
  );
endinterface

// File: rtl/risc_v_cpu.sv
// Single-cycle RV32I core: one instruction retires per rising clock edge.
// Memories, PC and register bank are separate instances for hierarchical access.
module risc_v_cpu_imem #(
  parameter int BYTES = 1024,
  parameter int AW    = $clog2(BYTES)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_addr,
  output logic [31:0]   o_instr
);
  logic [7:0] memory [0:BYTES-1];
  logic [AW-1:0] w_a1, w_a2, w_a3;

  // Byte-load port, tied off in the core; programs are preloaded externally.
  always_ff @(posedge i_clk) begin
    if (i_we) memory[i_waddr] <= i_wdata;
  end

  assign w_a1 = i_addr + AW'(1);
  assign w_a2 = i_addr + AW'(2);
  assign w_a3 = i_addr + AW'(3);
  assign o_instr = {memory[w_a3], memory[w_a2],
                    memory[w_a1], memory[i_addr]};
endmodule

module risc_v_cpu_pc (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_next,
  output logic [31:0] o_pc
);
  logic [31:0] pc_addr;

  always_ff @(posedge i_clk) begin
    if (i_rst) pc_addr <= '0;
    else       pc_addr <= i_next;
  end

  assign o_pc = pc_addr;
endmodule

module risc_v_cpu_regs (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  output logic [31:0] o_rs1,
  output logic [31:0] o_rs2
);
  logic [31:0] registers [0:31];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (i_we && i_rd != 5'd0) begin
      registers[i_rd] <= i_wdata;
    end
  end

  assign o_rs1 = (i_rs1 == 5'd0) ? 32'd0 : registers[i_rs1];
  assign o_rs2 = (i_rs2 == 5'd0) ? 32'd0 : registers[i_rs2];
endmodule

module risc_v_cpu_dmem #(
  parameter int WORDS = 256
) (
  input logic          i_clk,
  risc_v_cpu_if.slave  bus
);
  logic [31:0] memory [0:WORDS-1];

  always_ff @(posedge i_clk) begin
    if (bus.we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.be[b]) memory[bus.idx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  assign bus.rdata = memory[bus.idx];
endmodule

module risc_v_cpu #(
  parameter int IMEM_BYTES = 1024,
  parameter int DMEM_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] out
);
  localparam int IAW = $clog2(IMEM_BYTES);
  localparam int DAW = $clog2(DMEM_WORDS);

  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;

  logic [31:0] w_pc, w_instr, w_next_pc;
  logic [31:0] w_rs1v, w_rs2v, w_imm;
  logic [31:0] w_a, w_b, w_alu, w_ld;
  logic [31:0] w_result, w_st_data;
  logic [3:0]  w_be;
  logic [6:0]  w_op;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3, w_alu_f3;
  logic        w_sub, w_take, w_we, w_out_en;
  logic        w_is_br, w_is_st, w_is_reg, w_is_imm;
  logic [31:0] r_out;

  risc_v_cpu_if #(.AW(DAW)) w_dbus ();

  risc_v_cpu_imem #(.BYTES(IMEM_BYTES)) uut_instruction (
    .i_clk   (clock),
    .i_we    (1'b0),
    .i_waddr ('0),
    .i_wdata (8'd0),
    .i_addr  (w_pc[IAW-1:0]),
    .o_instr (w_instr)
  );

  risc_v_cpu_pc program_counter (
    .i_clk  (clock),
    .i_rst  (reset),
    .i_next (w_next_pc),
    .o_pc   (w_pc)
  );

  risc_v_cpu_regs registers_bank (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_we    (w_we),
    .i_rd    (w_rd),
    .i_wdata (w_result),
    .i_rs1   (w_rs1),
    .i_rs2   (w_rs2),
    .o_rs1   (w_rs1v),
    .o_rs2   (w_rs2v)
  );

  risc_v_cpu_dmem #(.WORDS(DMEM_WORDS)) memory (
    .i_clk (clock),
    .bus   (w_dbus.slave)
  );

  assign w_op  = w_instr[6:0];
  assign w_rd  = w_instr[11:7];
  assign w_f3  = w_instr[14:12];
  assign w_rs1 = w_instr[19:15];
  assign w_rs2 = w_instr[24:20];

  assign w_is_br  = (w_op == OP_BR);
  assign w_is_st  = (w_op == OP_ST);
  assign w_is_reg = (w_op == OP_REG);
  assign w_is_imm = (w_op == OP_IMM);

  always_comb begin
    w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
    case (w_op)
      OP_LUI, OP_AUI:
        w_imm = {w_instr[31:12], 12'd0};
      OP_JAL:
        w_imm = {{12{w_instr[31]}}, w_instr[19:12], w_instr[20],
                 w_instr[30:21], 1'b0};
      OP_BR:
        w_imm = {{20{w_instr[31]}}, w_instr[7], w_instr[30:25],
                 w_instr[11:8], 1'b0};
      OP_ST:
        w_imm = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
      default: ;
    endcase
  end

  // Non-ALU opcodes reuse the adder: addresses, AUIPC, and branch difference.
  assign w_a      = (w_op == OP_AUI) ? w_pc : w_rs1v;
  assign w_b      = (w_is_reg || w_is_br) ? w_rs2v : w_imm;
  assign w_alu_f3 = (w_is_reg || w_is_imm) ? w_f3 : 3'b000;
  assign w_sub    = w_is_br || (w_is_reg && w_instr[30]);

  always_comb begin
    w_alu = w_a + w_b;
    case (w_alu_f3)
      3'b000: w_alu = w_sub ? w_a - w_b : w_a + w_b;
      3'b001: w_alu = w_a << w_b[4:0];
      3'b010: w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
      3'b011: w_alu = {31'd0, w_a < w_b};
      3'b100: w_alu = w_a ^ w_b;
      3'b101: w_alu = w_instr[30] ? 32'($signed(w_a) >>> w_b[4:0])
                                  : w_a >> w_b[4:0];
      3'b110: w_alu = w_a | w_b;
      default: w_alu = w_a & w_b;
    endcase
  end

  always_comb begin
    w_take = 1'b0;
    case (w_f3)
      3'b000: w_take = (w_rs1v == w_rs2v);
      3'b001: w_take = (w_rs1v != w_rs2v);
      3'b100: w_take = $signed(w_rs1v) < $signed(w_rs2v);
      3'b101: w_take = $signed(w_rs1v) >= $signed(w_rs2v);
      3'b110: w_take = w_rs1v < w_rs2v;
      3'b111: w_take = w_rs1v >= w_rs2v;
      default: ;
    endcase
  end

  always_comb begin
    w_next_pc = w_pc + 32'd4;
    unique case (1'b1)
      w_is_br && w_take: w_next_pc = w_pc + w_imm;
      w_op == OP_JAL:    w_next_pc = w_pc + w_imm;
      w_op == OP_JLR:    w_next_pc = {w_alu[31:1], 1'b0};
      default: ;
    endcase
  end

  logic [31:0] w_word, w_lane;
  assign w_word = w_dbus.rdata;
  assign w_lane = w_word >> {w_alu[1:0], 3'b000};

  always_comb begin
    w_ld = w_word;
    case (w_f3)
      3'b000: w_ld = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001: w_ld = w_alu[1] ? {{16{w_word[31]}}, w_word[31:16]}
                              : {{16{w_word[15]}}, w_word[15:0]};
      3'b100: w_ld = {24'd0, w_lane[7:0]};
      3'b101: w_ld = w_alu[1] ? {16'd0, w_word[31:16]}
                              : {16'd0, w_word[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    w_be      = 4'b1111;
    w_st_data = w_rs2v;
    case (w_f3)
      3'b000: begin
        w_be      = 4'b0001 << w_alu[1:0];
        w_st_data = {4{w_rs2v[7:0]}};
      end
      3'b001: begin
        w_be      = w_alu[1] ? 4'b1100 : 4'b0011;
        w_st_data = {2{w_rs2v[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_dbus.idx   = w_alu[DAW+1:2];
  assign w_dbus.wdata = w_st_data;
  assign w_dbus.be    = w_be;
  assign w_dbus.we    = w_is_st && !reset;

  always_comb begin
    w_result = w_alu;
    w_we     = 1'b1;
    w_out_en = 1'b1;
    case (w_op)
      OP_LUI:         w_result = w_imm;
      OP_JAL, OP_JLR: w_result = w_pc + 32'd4;
      OP_LD:          w_result = w_ld;
      OP_AUI, OP_IMM, OP_REG: ;
      OP_ST, OP_BR:   w_we = 1'b0;
      default: begin
        w_we     = 1'b0;
        w_out_en = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)         r_out <= '0;
    else if (w_out_en) r_out <= w_result;
  end

  assign out = r_out;
endmodule

// File: tb/tb_risc_v_cpu.sv
// Directed program bench for risc_v_cpu.
// Loads a hand-assembled program and checks state after each retired instruction.
module tb_risc_v_cpu;
  logic        clock;
  logic        reset;
  logic [31:0] out;

  int n_chk;
  int n_fail;

  risc_v_cpu dut (
    .clock (clock),
    .reset (reset),
    .out   (out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(logic [6:0] op, logic [2:0] f3,
                                        logic [4:0] rd, logic [4:0] rs1,
                                        logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2,
                                        logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(logic [2:0] f3, logic [4:0] rs2,
                                        logic [4:0] rs1, logic [11:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(logic [2:0] f3, logic [4:0] rs1,
                                        logic [4:0] rs2, logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(logic [4:0] rd, logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  task automatic put(input int addr, input logic [31:0] ins);
    for (int k = 0; k < 4; k++)
      dut.uut_instruction.memory[addr + k] = ins[8*k +: 8];
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] rg(input int i);
    return dut.registers_bank.registers[i];
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    for (int i = 0; i < 1024; i++) dut.uut_instruction.memory[i] = 8'h00;
    for (int i = 0; i < 256; i++) dut.memory.memory[i] = 32'h0;

    put(32'h00, enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd5));
    put(32'h04, enc_i(7'h13, 3'd0, 5'd2, 5'd0, 12'hFFD));
    put(32'h08, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
    put(32'h0C, enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4));
    put(32'h10, enc_i(7'h13, 3'd0, 5'd0, 5'd0, 12'd7));
    put(32'h14, enc_s(3'd2, 5'd1, 5'd0, 12'd8));
    put(32'h18, enc_i(7'h03, 3'd2, 5'd5, 5'd0, 12'd8));
    put(32'h1C, enc_s(3'd0, 5'd2, 5'd0, 12'd9));
    put(32'h20, enc_b(3'd0, 5'd1, 5'd1, 13'd8));
    put(32'h24, enc_i(7'h13, 3'd0, 5'd10, 5'd0, 12'd1));
    put(32'h28, enc_i(7'h03, 3'd4, 5'd6, 5'd0, 12'd9));
    put(32'h2C, enc_i(7'h03, 3'd0, 5'd7, 5'd0, 12'd9));
    put(32'h30, enc_b(3'd1, 5'd1, 5'd1, 13'd8));
    put(32'h34, enc_b(3'd6, 5'd2, 5'd1, 13'd8));
    put(32'h38, enc_b(3'd4, 5'd2, 5'd1, 13'd8));
    put(32'h3C, enc_i(7'h13, 3'd0, 5'd10, 5'd0, 12'd1));
    put(32'h40, enc_j(5'd1, 21'd16));
    put(32'h44, {20'h12345, 5'd8, 7'h37});
    put(32'h48, {20'h00001, 5'd9, 7'h17});
    put(32'h4C, enc_j(5'd0, 21'd12));
    put(32'h50, enc_i(7'h67, 3'd0, 5'd0, 5'd1, 12'd0));
    put(32'h54, enc_i(7'h13, 3'd0, 5'd10, 5'd0, 12'd1));
    put(32'h58, 32'h00000073);
    put(32'h5C, enc_i(7'h13, 3'd5, 5'd11, 5'd2, 12'h401));
    put(32'h60, enc_i(7'h13, 3'd3, 5'd12, 5'd1, 12'h045));
    put(32'h64, enc_s(3'd1, 5'd2, 5'd0, 12'd14));
    put(32'h68, enc_i(7'h03, 3'd1, 5'd13, 5'd0, 12'd14));
    put(32'h6C, enc_i(7'h03, 3'd5, 5'd14, 5'd0, 12'd14));

    step();
    chk("rst_pc", dut.program_counter.pc_addr, 32'h0);
    chk("rst_out", out, 32'h0);
    reset = 1'b0;

    step();
    chk("addi_x1", rg(1), 32'd5);
    chk("addi_pc", dut.program_counter.pc_addr, 32'h4);
    chk("addi_out", out, 32'd5);
    step();
    chk("addi_neg", rg(2), 32'hFFFFFFFD);
    step();
    chk("add", rg(3), 32'd2);
    step();
    chk("sub", rg(4), 32'd8);
    chk("sub_pc", dut.program_counter.pc_addr, 32'd16);
    step();
    chk("x0", rg(0), 32'd0);
    chk("x0_out", out, 32'd7);

    step();
    chk("sw_mem", dut.memory.memory[2], 32'd5);
    chk("sw_out", out, 32'd8);
    step();
    chk("lw", rg(5), 32'd5);
    step();
    chk("sb_mem", dut.memory.memory[2], 32'h0000FD05);
    chk("sb_out", out, 32'd9);

    step();
    chk("beq_pc", dut.program_counter.pc_addr, 32'h28);
    chk("beq_out", out, 32'd0);
    step();
    chk("lbu", rg(6), 32'h000000FD);
    step();
    chk("lb", rg(7), 32'hFFFFFFFD);
    step();
    chk("bne_pc", dut.program_counter.pc_addr, 32'h34);
    step();
    chk("bltu_pc", dut.program_counter.pc_addr, 32'h38);
    step();
    chk("blt_pc", dut.program_counter.pc_addr, 32'h40);
    chk("blt_out", out, 32'hFFFFFFF8);

    step();
    chk("jal_x1", rg(1), 32'h44);
    chk("jal_pc", dut.program_counter.pc_addr, 32'h50);
    step();
    chk("jalr_pc", dut.program_counter.pc_addr, 32'h44);
    step();
    chk("lui", rg(8), 32'h12345000);
    step();
    chk("auipc", rg(9), 32'h00001048);
    step();
    chk("jal0_pc", dut.program_counter.pc_addr, 32'h58);
    chk("jal0_out", out, 32'h50);
    step();
    chk("ecall_pc", dut.program_counter.pc_addr, 32'h5C);
    chk("ecall_out", out, 32'h50);
    step();
    chk("srai", rg(11), 32'hFFFFFFFE);
    step();
    chk("sltiu", rg(12), 32'd1);
    step();
    chk("sh_mem", dut.memory.memory[3], 32'hFFFD0000);
    step();
    chk("lh", rg(13), 32'hFFFFFFFD);
    step();
    chk("lhu", rg(14), 32'h0000FFFD);
    chk("skipped", rg(10), 32'd0);

    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_pc", dut.program_counter.pc_addr, 32'h0);
    chk("rst2_x1", rg(1), 32'd0);
    chk("rst2_x9", rg(9), 32'd0);
    chk("rst2_out", out, 32'd0);
    chk("rst2_mem", dut.memory.memory[2], 32'h0000FD05);
    step();
    chk("restart_x1", rg(1), 32'd5);
    chk("restart_pc", dut.program_counter.pc_addr, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
